// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - SECDED (39,32) codeword helpers and scrubber state type
package ecc_pkg;
    localparam int CW_W   = 39;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {INIT, WAIT, CHECK, FIX} scrub_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ce;
        logic              ue;
    } dec_t;

    // Data fills the non-power-of-two Hamming positions LSB first; bit 0 is overall parity.
    function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        logic [5:0]      s;
        int              di;
        cw = '0;
        di = 0;
        for (int pos = 3; pos < CW_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[di];
                di++;
            end
        end
        s = '0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if (cw[pos]) s = s ^ 6'(pos);
        end
        for (int k = 0; k < 6; k++) cw[1 << k] = s[k];
        cw[0] = ^cw[CW_W-1:1];
        return cw;
    endfunction

    function automatic dec_t decode(input logic [CW_W-1:0] cw);
        dec_t            r;
        logic [CW_W-1:0] fixed;
        logic [5:0]      s;
        logic            p;
        int              di;
        s = '0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if (cw[pos]) s = s ^ 6'(pos);
        end
        p     = ^cw;
        fixed = cw;
        r.ce  = 1'b0;
        r.ue  = 1'b0;
        if (p && (s <= 6'd38)) begin
            fixed = cw ^ (CW_W'(1) << s);
            r.ce  = 1'b1;
        end else if (s != 6'd0) begin
            r.ue = 1'b1;
        end
        r.data = '0;
        di     = 0;
        for (int pos = 3; pos < CW_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                r.data[di] = fixed[pos];
                di++;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/secded_decode.sv
// rtl/secded_decode.sv - combinational SECDED check/correct of one 39-bit codeword
module secded_decode
    import ecc_pkg::*;
(
    input  logic [CW_W-1:0]   i_cw,
    output logic [DATA_W-1:0] o_data,
    output logic              o_ce,
    output logic              o_ue
);
    dec_t w_dec;

    always_comb w_dec = decode(i_cw);

    assign o_data = w_dec.data;
    assign o_ce   = w_dec.ce;
    assign o_ue   = w_dec.ue;
endmodule

// File: rtl/ecc_data_memory.sv
// rtl/ecc_data_memory.sv - SECDED data memory with init, background scrub and error injection
module ecc_data_memory
    import ecc_pkg::*;
#(
    parameter int ADDR_W         = 10,
    parameter int SCRUB_INTERVAL = 256
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              MemWrite,
    input  logic [31:0]       A,
    input  logic [31:0]       WD,
    input  logic [CW_W-1:0]   inject_mask,
    output logic [31:0]       ReadData,
    output logic              rd_ce,
    output logic              rd_ue,
    output logic              init_done,
    output logic [15:0]       ce_count,
    output logic              ue_sticky
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

    logic [CW_W-1:0]   r_mem [DEPTH];
    scrub_state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_init_addr, r_scrub_addr;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_init_done, r_ue_sticky;
    logic [15:0]       r_ce_count;
    logic [CW_W-1:0]   r_fix_cw;

    logic [ADDR_W-1:0] w_core_addr, w_mem_waddr;
    logic [CW_W-1:0]   w_mem_wdata;
    logic [DATA_W-1:0] w_core_data, w_scr_data;
    logic              w_core_ce, w_core_ue, w_scr_ce, w_scr_ue;
    logic              w_core_we, w_scrub_hit, w_wait_done, w_mem_we;
    logic              w_init_last, w_advance, w_fix_load, w_fix_write, w_ue_set;
    logic              w_unused;

    assign w_core_addr = A[ADDR_W+1:2];
    assign w_unused    = ^{A[31:ADDR_W+2], A[1:0]};
    assign w_core_we   = MemWrite & r_init_done;
    assign w_scrub_hit = w_core_we && (w_core_addr == r_scrub_addr);
    assign w_wait_done = (r_wait_cnt == CNT_W'(SCRUB_INTERVAL - 1));

    secded_decode u_core_dec (
        .i_cw   (r_mem[w_core_addr]),
        .o_data (w_core_data),
        .o_ce   (w_core_ce),
        .o_ue   (w_core_ue)
    );

    secded_decode u_scrub_dec (
        .i_cw   (r_mem[r_scrub_addr]),
        .o_data (w_scr_data),
        .o_ce   (w_scr_ce),
        .o_ue   (w_scr_ue)
    );

    assign ReadData  = r_init_done ? w_core_data : '0;
    assign rd_ce     = r_init_done & w_core_ce;
    assign rd_ue     = r_init_done & w_core_ue;
    assign init_done = r_init_done;
    assign ce_count  = r_ce_count;
    assign ue_sticky = r_ue_sticky;

    always_comb begin
        w_state_nxt = r_state;
        w_init_last = 1'b0;
        w_advance   = 1'b0;
        w_fix_load  = 1'b0;
        w_fix_write = 1'b0;
        w_ue_set    = 1'b0;
        case (r_state)
            INIT: begin
                if (r_init_addr == ADDR_W'(DEPTH - 1)) begin
                    w_init_last = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (w_wait_done) w_state_nxt = CHECK;
            end
            CHECK: begin
                // A same-cycle core write makes the word fresh, so the stale check is dropped.
                if (w_scrub_hit) begin
                    w_advance = 1'b1;
                end else if (w_scr_ce) begin
                    w_fix_load  = 1'b1;
                    w_state_nxt = FIX;
                end else begin
                    w_advance = 1'b1;
                    w_ue_set  = w_scr_ue;
                end
            end
            FIX: begin
                if (!MemWrite) begin
                    w_fix_write = 1'b1;
                    w_advance   = 1'b1;
                end else if (w_core_addr == r_scrub_addr) begin
                    w_advance = 1'b1;
                end
            end
            default: w_state_nxt = INIT;
        endcase
        if (w_advance) w_state_nxt = WAIT;
    end

    // Single write port: core first, then init zeroing, then scrub writeback.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = w_core_addr;
        w_mem_wdata = encode(WD) ^ inject_mask;
        if (w_core_we) begin
            w_mem_we = 1'b1;
        end else if (r_state == INIT) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_init_addr;
            w_mem_wdata = '0;
        end else if (w_fix_write) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_scrub_addr;
            w_mem_wdata = r_fix_cw;
        end
        if (rst_in) w_mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst_in) r_state <= INIT;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_init_addr  <= '0;
            r_scrub_addr <= '0;
            r_wait_cnt   <= '0;
            r_init_done  <= 1'b0;
            r_ue_sticky  <= 1'b0;
            r_ce_count   <= '0;
            r_fix_cw     <= '0;
        end else begin
            if (r_state == INIT) r_init_addr <= r_init_addr + 1'b1;
            if (w_init_last)     r_init_done <= 1'b1;
            if (r_state == WAIT) r_wait_cnt  <= w_wait_done ? '0 : r_wait_cnt + 1'b1;
            if (w_advance)       r_scrub_addr <= r_scrub_addr + 1'b1;
            if (w_ue_set)        r_ue_sticky <= 1'b1;
            if (w_fix_load)      r_fix_cw    <= encode(w_scr_data);
            if (w_fix_write && (r_ce_count != 16'hFFFF)) r_ce_count <= r_ce_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_ecc_data_memory.sv
// tb/tb_ecc_data_memory.sv - vector-table and scoreboard bench for ecc_data_memory
module tb_ecc_data_memory;
    localparam int ADDR_W = 4;
    localparam int SI     = 4;
    localparam int SWEEP  = 130;
    localparam int NVEC   = 11;

    logic        clk = 1'b0;
    logic        rst_in, MemWrite;
    logic [31:0] A, WD, ReadData;
    logic [38:0] inject_mask;
    logic        rd_ce, rd_ue, init_done, ue_sticky;
    logic [15:0] ce_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  word;
        logic [31:0] wdata;
        logic [38:0] mask;
        logic [31:0] exp_data;
        logic        exp_ce;
        logic        exp_ue;
    } vec_t;

    vec_t vecs[NVEC];
    vec_t exp_q[$];

    ecc_data_memory #(.ADDR_W(ADDR_W), .SCRUB_INTERVAL(SI)) dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .MemWrite    (MemWrite),
        .A           (A),
        .WD          (WD),
        .inject_mask (inject_mask),
        .ReadData    (ReadData),
        .rd_ce       (rd_ce),
        .rd_ue       (rd_ue),
        .init_done   (init_done),
        .ce_count    (ce_count),
        .ue_sticky   (ue_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [38:0] bit39(input int p);
        return 39'(1) << p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_init(input string name);
        int cycles = 0;
        while (!init_done && cycles < 64) begin
            @(negedge clk);
            cycles++;
        end
        check(name, 64'(cycles), 64'd16);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_in = 1'b1; MemWrite = 1'b0; inject_mask = '0;
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
        wait_init("init_len");
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input logic [38:0] mask);
        A = addr; WD = data; inject_mask = mask; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0; inject_mask = '0;
        #1;
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] d,
                              input logic ce, input logic ue);
        A = addr; MemWrite = 1'b0;
        #1;
        check(name, 64'({ReadData, rd_ce, rd_ue}), 64'({d, ce, ue}));
    endtask

    task automatic idle(input int n);
        MemWrite = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   n_ce;
        logic any_ue;
        vec_t e;

        vecs[0]  = '{4'd1,  32'hA5A5A5A5, 39'h0, 32'hA5A5A5A5, 1'b0, 1'b0};
        vecs[1]  = '{4'd2,  32'hDEADBEEF, bit39(0), 32'hDEADBEEF, 1'b1, 1'b0};
        vecs[2]  = '{4'd3,  32'h00000000, bit39(1), 32'h00000000, 1'b1, 1'b0};
        vecs[3]  = '{4'd4,  32'hFFFFFFFF, bit39(3), 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[4]  = '{4'd5,  32'h80000001, bit39(38), 32'h80000001, 1'b1, 1'b0};
        vecs[5]  = '{4'd6,  32'h13579BDF, bit39(32), 32'h13579BDF, 1'b1, 1'b0};
        vecs[6]  = '{4'd7,  32'h12345678, bit39(3) | bit39(5), 32'h1234567B, 1'b0, 1'b1};
        vecs[7]  = '{4'd8,  32'h0F0F0F0F, bit39(32) | bit39(8) | bit39(0), 32'h0F0F0F0F, 1'b0, 1'b1};
        vecs[8]  = '{4'd9,  32'hCAFEF00D, bit39(3) | bit39(5) | bit39(6), 32'hCAFEF00A, 1'b1, 1'b0};
        vecs[9]  = '{4'd10, 32'h00000001, 39'h0, 32'h00000001, 1'b0, 1'b0};
        vecs[10] = '{4'd11, 32'hFFFFFFFF, bit39(37), 32'hFFFFFFFF, 1'b1, 1'b0};

        rst_in = 1'b1; MemWrite = 1'b0; A = '0; WD = '0; inject_mask = '0;
        repeat (3) @(negedge clk);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_ce_count", 64'(ce_count), 64'd0);
        check("rst_ue_sticky", 64'(ue_sticky), 64'd0);
        check("rst_read", 64'({ReadData, rd_ce, rd_ue}), 64'd0);
        rst_in = 1'b0;
        wait_init("init_len");
        read_check("blank_w0", 32'h00, 32'h0, 1'b0, 1'b0);
        read_check("blank_w7", 32'h1C, 32'h0, 1'b0, 1'b0);
        read_check("blank_w15", 32'h3C, 32'h0, 1'b0, 1'b0);

        write_word(32'h28, 32'hDEADBEEF, bit39(5));
        check("t2_read", 64'({ReadData, rd_ce, rd_ue}), 64'({32'hDEADBEEF, 1'b1, 1'b0}));
        idle(SWEEP);
        check("t2_ce_count", 64'(ce_count), 64'd1);
        read_check("t2_reread", 32'h28, 32'hDEADBEEF, 1'b0, 1'b0);

        do_reset();
        write_word(32'h0C, 32'h12345678, 39'h3);
        check("t3_read", 64'({ReadData, rd_ce, rd_ue}), 64'({32'h12345678, 1'b0, 1'b1}));
        idle(SWEEP);
        check("t3_ue_sticky", 64'(ue_sticky), 64'd1);
        check("t3_ce_count", 64'(ce_count), 64'd0);
        read_check("t3_reread", 32'h0C, 32'h12345678, 1'b0, 1'b1);

        do_reset();
        n_ce = 0;
        any_ue = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            write_word(32'h5000_0003 | (32'(vecs[i].word) << 2), vecs[i].wdata, vecs[i].mask);
            exp_q.push_back(vecs[i]);
            if (vecs[i].exp_ce) n_ce++;
            any_ue = any_ue | vecs[i].exp_ue;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("vec%0d_read", i), 64'({ReadData, rd_ce, rd_ue}),
                      64'({e.exp_data, e.exp_ce, e.exp_ue}));
            end
        end
        idle(SWEEP);
        check("vec_ce_count", 64'(ce_count), 64'(n_ce));
        check("vec_ue_sticky", 64'(ue_sticky), 64'(any_ue));
        for (int i = 0; i < NVEC; i++) begin
            read_check($sformatf("vec%0d_scrubbed", i), 32'(vecs[i].word) << 2,
                       vecs[i].exp_data, 1'b0, vecs[i].exp_ue);
        end

        do_reset();
        write_word(32'h08, 32'h0BADF00D, bit39(9));
        repeat (13) @(negedge clk);
        write_word(32'h08, 32'hCAFEF00D, 39'h0);
        check("t4_read", 64'({ReadData, rd_ce, rd_ue}), 64'({32'hCAFEF00D, 1'b0, 1'b0}));
        idle(SWEEP);
        check("t4_ce_count", 64'(ce_count), 64'd0);
        read_check("t4_reread", 32'h08, 32'hCAFEF00D, 1'b0, 1'b0);

        do_reset();
        write_word(32'h04, 32'h11112222, bit39(7));
        repeat (9) @(negedge clk);
        A = 32'h14; WD = 32'h55556666; inject_mask = '0; MemWrite = 1'b1;
        @(negedge clk); #1;
        check("t5_stall1", 64'(ce_count), 64'd0);
        @(negedge clk); #1;
        check("t5_stall2", 64'(ce_count), 64'd0);
        @(negedge clk);
        MemWrite = 1'b0; A = 32'h04; #1;
        check("t5_stall3", 64'(ce_count), 64'd0);
        check("t5_prefix", 64'({ReadData, rd_ce}), 64'({32'h11112222, 1'b1}));
        @(negedge clk); #1;
        check("t5_ce_count", 64'(ce_count), 64'd1);
        read_check("t5_fixed", 32'h04, 32'h11112222, 1'b0, 1'b0);
        read_check("t5_other", 32'h14, 32'h55556666, 1'b0, 1'b0);

        write_word(32'h30, 32'h00000000, bit39(16));
        write_word(32'h34, 32'h77778888, bit39(16) | bit39(17));
        idle(SWEEP);
        check("t6_pre_ce", 64'(ce_count), 64'd2);
        check("t6_pre_ue", 64'(ue_sticky), 64'd1);
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        A = 32'h04; #1;
        check("t6_rst_ce", 64'(ce_count), 64'd0);
        check("t6_rst_ue", 64'(ue_sticky), 64'd0);
        check("t6_rst_init", 64'(init_done), 64'd0);
        check("t6_rst_read", 64'(ReadData), 64'd0);
        rst_in = 1'b0;
        wait_init("t6_reinit_len");
        for (int w = 0; w < 16; w++) begin
            read_check($sformatf("t6_zero_w%0d", w), 32'(w) << 2, 32'h0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
